// File: rtl/m3_ramp_ctrl_if.sv
// Command and status bundle between a motion sequencer and the M3 ramp controller.
// The sequencer side issues request pulses; the controller side reports period and state.
interface m3_ramp_ctrl_if;
    logic        startReqI;
    logic        stopReqI;
    logic        forceStopI;
    logic        speedIncI;
    logic        speedDecI;
    logic        roundTickI;
    logic        m3startO;
    logic [31:0] dstRoundLenO;
    logic        busyO;
    logic [1:0]  stateO;

    modport master (
        output startReqI, stopReqI, forceStopI, speedIncI, speedDecI, roundTickI,
        input  m3startO, dstRoundLenO, busyO, stateO
    );

    modport slave (
        input  startReqI, stopReqI, forceStopI, speedIncI, speedDecI, roundTickI,
        output m3startO, dstRoundLenO, busyO, stateO
    );
endinterface

// File: rtl/m3_ramp_ctrl.sv
// M3 speed ramp controller: slews the per-round slice period toward a target at round
// boundaries, with ramped and immediate stop paths.
module m3_ramp_ctrl #(
    parameter logic [21:0] PERIOD_MAX  = 22'd400000,
    parameter logic [21:0] PERIOD_MIN  = 22'd2000,
    parameter logic [21:0] RAMP_STEP   = 22'd1000,
    parameter logic [21:0] TARGET_STEP = 22'd5000,
    parameter logic [21:0] TGT_INIT    = 22'd100000
) (
    input  logic          clkI,
    input  logic          rstI,
    m3_ramp_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        DECEL = 2'd3
    } stateT;

    stateT       state;
    logic [21:0] curPeriod;
    logic [21:0] target;
    logic [21:0] targetNext;
    logic [21:0] goal;
    logic [21:0] tickPeriod;
    logic [22:0] incFloor;
    logic [22:0] decSum;

    // Moves cur by at most RAMP_STEP toward goal, landing exactly on goal when close enough.
    function automatic logic [21:0] rampNext(input logic [21:0] cur, input logic [21:0] g);
        logic [21:0] r;
        if (cur > g) begin
            r = ((cur - g) <= RAMP_STEP) ? g : (cur - RAMP_STEP);
        end else begin
            r = ((g - cur) <= RAMP_STEP) ? g : (cur + RAMP_STEP);
        end
        return r;
    endfunction

    always_comb begin
        incFloor   = {1'b0, PERIOD_MIN} + {1'b0, TARGET_STEP};
        decSum     = {1'b0, target} + {1'b0, TARGET_STEP};
        targetNext = target;
        if (bus.speedIncI && !bus.speedDecI) begin
            targetNext = ({1'b0, target} >= incFloor) ? (target - TARGET_STEP) : PERIOD_MIN;
        end else if (bus.speedDecI && !bus.speedIncI) begin
            targetNext = (decSum > {1'b0, PERIOD_MAX}) ? PERIOD_MAX : decSum[21:0];
        end
        goal       = (state == DECEL) ? PERIOD_MAX : target;
        tickPeriod = rampNext(curPeriod, goal);
    end

    always_ff @(posedge clkI) begin
        if (rstI) begin
            state     <= IDLE;
            curPeriod <= PERIOD_MAX;
            target    <= TGT_INIT;
        end else begin
            target <= targetNext;
            if (bus.forceStopI) begin
                state     <= IDLE;
                curPeriod <= PERIOD_MAX;
            end else begin
                if (bus.roundTickI && (state != IDLE)) begin
                    curPeriod <= tickPeriod;
                end
                case (state)
                    IDLE: begin
                        if (bus.startReqI && !bus.stopReqI) state <= RAMP;
                    end
                    RAMP: begin
                        if (bus.stopReqI) state <= DECEL;
                        else if (bus.roundTickI && (tickPeriod == target)) state <= RUN;
                    end
                    RUN: begin
                        if (bus.stopReqI) state <= DECEL;
                        else if (curPeriod != target) state <= RAMP;
                    end
                    DECEL: begin
                        // A fresh start resumes from the present period instead of finishing the stop.
                        if (bus.startReqI && !bus.stopReqI) state <= RAMP;
                        else if (bus.roundTickI && (tickPeriod == PERIOD_MAX)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.m3startO     = (state != IDLE);
    assign bus.busyO        = (state != IDLE);
    assign bus.stateO       = state;
    assign bus.dstRoundLenO = {10'd0, curPeriod};

endmodule

// File: tb/tb_m3_ramp_ctrl.sv
// Directed scoreboard bench for m3_ramp_ctrl using small periods so each ramp step is visible.
module tb_m3_ramp_ctrl;

    logic clkI = 1'b0;
    logic rstI = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;

    typedef struct {
        string       tag;
        logic [1:0]  expState;
        logic [31:0] expLen;
        logic        expStart;
        logic [21:0] expTarget;
    } expT;

    expT scoreQ[$];

    m3_ramp_ctrl_if bus ();

    m3_ramp_ctrl #(
        .PERIOD_MAX (22'd1000),
        .PERIOD_MIN (22'd100),
        .RAMP_STEP  (22'd300),
        .TARGET_STEP(22'd200),
        .TGT_INIT   (22'd400)
    ) dut (
        .clkI(clkI),
        .rstI(rstI),
        .bus (bus.slave)
    );

    always #5 clkI = ~clkI;

    // Drives one cycle of pulses, records what the design must show afterwards, then releases.
    task automatic applyStimulus(input string tag, input logic start, input logic stop,
                                 input logic force_, input logic inc, input logic dec,
                                 input logic tick, input logic [1:0] eState,
                                 input logic [31:0] eLen, input logic eStart,
                                 input logic [21:0] eTarget);
        expT e;
        bus.startReqI  = start;
        bus.stopReqI   = stop;
        bus.forceStopI = force_;
        bus.speedIncI  = inc;
        bus.speedDecI  = dec;
        bus.roundTickI = tick;
        e.tag = tag; e.expState = eState; e.expLen = eLen;
        e.expStart = eStart; e.expTarget = eTarget;
        scoreQ.push_back(e);
        @(posedge clkI);
        #1;
        bus.startReqI  = 1'b0;
        bus.stopReqI   = 1'b0;
        bus.forceStopI = 1'b0;
        bus.speedIncI  = 1'b0;
        bus.speedDecI  = 1'b0;
        bus.roundTickI = 1'b0;
    endtask

    task automatic checkOutput();
        expT e;
        if (scoreQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e = scoreQ.pop_front();
        assertCount++;
        assert (bus.stateO === e.expState) else begin
            failCount++;
            $error("[TB] FAIL %s.state observed=%0d expected=%0d", e.tag, bus.stateO, e.expState);
        end
        assertCount++;
        assert (bus.dstRoundLenO === e.expLen) else begin
            failCount++;
            $error("[TB] FAIL %s.len observed=%0d expected=%0d", e.tag, bus.dstRoundLenO, e.expLen);
        end
        assertCount++;
        assert (bus.m3startO === e.expStart && bus.busyO === e.expStart) else begin
            failCount++;
            $error("[TB] FAIL %s.start observed=%0b/%0b expected=%0b", e.tag, bus.m3startO, bus.busyO, e.expStart);
        end
        assertCount++;
        assert (dut.target === e.expTarget) else begin
            failCount++;
            $error("[TB] FAIL %s.target observed=%0d expected=%0d", e.tag, dut.target, e.expTarget);
        end
    endtask

    initial begin
        bus.startReqI  = 1'b0;
        bus.stopReqI   = 1'b0;
        bus.forceStopI = 1'b0;
        bus.speedIncI  = 1'b0;
        bus.speedDecI  = 1'b0;
        bus.roundTickI = 1'b0;

        rstI = 1'b1;
        @(posedge clkI);
        #1;
        applyStimulus("reset", 0, 0, 0, 0, 0, 1, 2'd0, 32'd1000, 1'b0, 22'd400);
        rstI = 1'b0;
        checkOutput();

        applyStimulus("start",     1, 0, 0, 0, 0, 0, 2'd1, 32'd1000, 1'b1, 22'd400); checkOutput();
        applyStimulus("rampHold",  0, 0, 0, 0, 0, 0, 2'd1, 32'd1000, 1'b1, 22'd400); checkOutput();
        applyStimulus("rampTick1", 0, 0, 0, 0, 0, 1, 2'd1, 32'd700,  1'b1, 22'd400); checkOutput();
        applyStimulus("rampTick2", 0, 0, 0, 0, 0, 1, 2'd2, 32'd400,  1'b1, 22'd400); checkOutput();
        applyStimulus("runStart",  1, 0, 0, 0, 0, 1, 2'd2, 32'd400,  1'b1, 22'd400); checkOutput();

        applyStimulus("inc1",      0, 0, 0, 1, 0, 0, 2'd2, 32'd400,  1'b1, 22'd200); checkOutput();
        applyStimulus("inc2Sat",   0, 0, 0, 1, 0, 0, 2'd1, 32'd400,  1'b1, 22'd100); checkOutput();
        applyStimulus("noTick",    0, 0, 0, 0, 0, 0, 2'd1, 32'd400,  1'b1, 22'd100); checkOutput();
        applyStimulus("toMin",     0, 0, 0, 0, 0, 1, 2'd2, 32'd100,  1'b1, 22'd100); checkOutput();

        applyStimulus("stop",      0, 1, 0, 0, 0, 0, 2'd3, 32'd100,  1'b1, 22'd100); checkOutput();
        applyStimulus("decel1",    0, 0, 0, 0, 0, 1, 2'd3, 32'd400,  1'b1, 22'd100); checkOutput();
        applyStimulus("decel2",    0, 0, 0, 0, 0, 1, 2'd3, 32'd700,  1'b1, 22'd100); checkOutput();
        applyStimulus("decelEnd",  0, 0, 0, 0, 0, 1, 2'd0, 32'd1000, 1'b0, 22'd100); checkOutput();
        applyStimulus("idleTick",  0, 0, 0, 0, 0, 1, 2'd0, 32'd1000, 1'b0, 22'd100); checkOutput();

        applyStimulus("dec1",      0, 0, 0, 0, 1, 0, 2'd0, 32'd1000, 1'b0, 22'd300); checkOutput();
        applyStimulus("dec2",      0, 0, 0, 0, 1, 0, 2'd0, 32'd1000, 1'b0, 22'd500); checkOutput();
        applyStimulus("restart",   1, 0, 0, 0, 0, 0, 2'd1, 32'd1000, 1'b1, 22'd500); checkOutput();
        applyStimulus("rampTo700", 0, 0, 0, 0, 0, 1, 2'd1, 32'd700,  1'b1, 22'd500); checkOutput();
        applyStimulus("forceTick", 0, 0, 1, 0, 0, 1, 2'd0, 32'd1000, 1'b0, 22'd500); checkOutput();

        applyStimulus("incDecBoth",0, 0, 0, 1, 1, 0, 2'd0, 32'd1000, 1'b0, 22'd500); checkOutput();
        applyStimulus("dec3",      0, 0, 0, 0, 1, 0, 2'd0, 32'd1000, 1'b0, 22'd700); checkOutput();
        applyStimulus("dec4",      0, 0, 0, 0, 1, 0, 2'd0, 32'd1000, 1'b0, 22'd900); checkOutput();
        applyStimulus("decSat",    0, 0, 0, 0, 1, 0, 2'd0, 32'd1000, 1'b0, 22'd1000); checkOutput();
        applyStimulus("decAtMax",  0, 0, 0, 0, 1, 0, 2'd0, 32'd1000, 1'b0, 22'd1000); checkOutput();
        applyStimulus("idleStop",  0, 1, 0, 0, 0, 0, 2'd0, 32'd1000, 1'b0, 22'd1000); checkOutput();
        applyStimulus("startStop", 1, 1, 0, 0, 0, 0, 2'd0, 32'd1000, 1'b0, 22'd1000); checkOutput();

        // Resume from DECEL: ramp down, stop partway, then restart before reaching the stop period.
        applyStimulus("inc3",      0, 0, 0, 1, 0, 0, 2'd0, 32'd1000, 1'b0, 22'd800); checkOutput();
        applyStimulus("inc4",      0, 0, 0, 1, 0, 0, 2'd0, 32'd1000, 1'b0, 22'd600); checkOutput();
        applyStimulus("start3",    1, 0, 0, 0, 0, 0, 2'd1, 32'd1000, 1'b1, 22'd600); checkOutput();
        applyStimulus("ramp3",     0, 0, 0, 0, 0, 1, 2'd1, 32'd700,  1'b1, 22'd600); checkOutput();
        applyStimulus("stop3",     0, 1, 0, 0, 0, 0, 2'd3, 32'd700,  1'b1, 22'd600); checkOutput();
        applyStimulus("resume",    1, 0, 0, 0, 0, 0, 2'd1, 32'd700,  1'b1, 22'd600); checkOutput();
        applyStimulus("resumeRun", 0, 0, 0, 0, 0, 1, 2'd2, 32'd600,  1'b1, 22'd600); checkOutput();

        rstI = 1'b1;
        applyStimulus("midReset",  0, 0, 0, 0, 0, 1, 2'd0, 32'd1000, 1'b0, 22'd400);
        rstI = 1'b0;
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
